// File: rtl/bus_pkg.sv
// Shared constants for the bus control FSM: bus codes, opcodes, ALU ops,
// fault codes, state encoding and the bus-code legality check.
package bus_pkg;

   localparam logic [3:0] SEL_RA = 4'b0000;
   localparam logic [3:0] SEL_RB = 4'b0001;
   localparam logic [3:0] SEL_RC = 4'b0010;
   localparam logic [3:0] SEL_R1 = 4'b0011;
   localparam logic [3:0] SEL_R2 = 4'b0100;
   localparam logic [3:0] SEL_R3 = 4'b0101;
   localparam logic [3:0] SEL_DR = 4'b0110;
   localparam logic [3:0] SEL_RD = 4'b0111;
   localparam logic [3:0] SEL_AC = 4'b1001;
   localparam logic [3:0] SEL_PC = 4'b1010;

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_MOV   = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_LOAD  = 4'b0100;
   localparam logic [3:0] OP_STORE = 4'b0101;
   localparam logic [3:0] OP_JMP   = 4'b0110;
   localparam logic [3:0] OP_JZ    = 4'b0111;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ILL_OP  = 2'd1;
   localparam logic [1:0] FAULT_ILL_SEL = 2'd2;
   localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } state_e;

   // Codes 1000 and 1011-1111 have no source/destination on the bus mux.
   function automatic logic is_legal_sel(input logic [3:0] code);
      return (code <= SEL_RD) || (code == SEL_AC) || (code == SEL_PC);
   endfunction

endpackage

// File: rtl/bus_ctrl_fsm.sv
// Fetch/decode/execute sequencer driving the 16-bit shared bus mux.
// Optional memory-request timeout enabled by defining MEM_TIMEOUT_EN.
module bus_ctrl_fsm
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [3:0]  ADDR_SRC_SEL   = 4'b1001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ir,
   input  logic        zero_flag,
   input  logic        mem_ack,
   output logic [3:0]  bus_sel,
   output logic [15:0] ld_en,
   output logic [2:0]  alu_op,
   output logic        ir_load,
   output logic        pc_inc,
   output logic        mem_req,
   output logic        mem_we,
   output logic        halted,
   output logic [1:0]  fault
);

   state_e     state_q, state_d;
   logic [1:0] fault_q, fault_d;

   logic [3:0] opcode, src, dst;
   logic [3:0] src_sel, addr_sel;
   logic       op_legal, uses_src, uses_dst;
   logic [1:0] dec_fault;
   logic       timeout;
   logic       unused_ir;

   assign opcode    = ir[15:12];
   assign src       = ir[11:8];
   assign dst       = ir[7:4];
   assign unused_ir = ^ir[3:0];

   // Guarded selects keep bus_sel legal even if ir or the parameter misbehave.
   assign src_sel  = is_legal_sel(src) ? src : SEL_PC;
   assign addr_sel = is_legal_sel(ADDR_SRC_SEL) ? ADDR_SRC_SEL : SEL_AC;

   always_comb begin
      op_legal = 1'b1;
      uses_src = 1'b0;
      uses_dst = 1'b0;
      case (opcode)
         OP_NOP, OP_LOAD, OP_HALT: ;
         OP_MOV: begin
            uses_src = 1'b1;
            uses_dst = 1'b1;
         end
         OP_ADD, OP_SUB, OP_STORE, OP_JMP, OP_JZ: uses_src = 1'b1;
         default: op_legal = 1'b0;
      endcase

      if (!op_legal)
         dec_fault = FAULT_ILL_OP;
      else if ((uses_src && !is_legal_sel(src)) || (uses_dst && !is_legal_sel(dst)))
         dec_fault = FAULT_ILL_SEL;
      else
         dec_fault = FAULT_NONE;
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       waiting;

   // Counter is zero whenever no request is outstanding, so entry to
   // FETCH/MEM always starts from a cleared count.
   assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack;
   assign timeout = waiting && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
   assign cnt_d   = waiting ? cnt_q + 8'd1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   logic [7:0] unused_tmo;
   assign unused_tmo = 8'(TIMEOUT_CYCLES);
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      bus_sel = SEL_PC;
      ld_en   = '0;
      alu_op  = ALU_PASS;
      ir_load = 1'b0;
      pc_inc  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      halted  = 1'b0;
      fault   = fault_q;

      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = ST_DECODE;
            end else if (timeout) begin
               fault_d = FAULT_TIMEOUT;
               state_d = ST_HALT;
            end
         end

         // DECODE always follows FETCH, so the held bus_sel is PC.
         ST_DECODE: begin
            fault = dec_fault;
            if (dec_fault != FAULT_NONE) begin
               fault_d = dec_fault;
               state_d = ST_HALT;
            end else if (opcode == OP_HALT) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d = ST_FETCH;
            case (opcode)
               OP_MOV: begin
                  bus_sel = src_sel;
                  if (is_legal_sel(dst)) ld_en[dst] = 1'b1;
               end
               OP_ADD: begin
                  bus_sel        = src_sel;
                  alu_op         = ALU_ADD;
                  ld_en[SEL_AC]  = 1'b1;
               end
               OP_SUB: begin
                  bus_sel        = src_sel;
                  alu_op         = ALU_SUB;
                  ld_en[SEL_AC]  = 1'b1;
               end
               OP_JMP: begin
                  bus_sel        = src_sel;
                  ld_en[SEL_PC]  = 1'b1;
               end
               OP_JZ: begin
                  if (zero_flag) begin
                     bus_sel       = src_sel;
                     ld_en[SEL_PC] = 1'b1;
                  end
               end
               OP_LOAD: begin
                  bus_sel = addr_sel;
                  state_d = ST_MEM;
               end
               OP_STORE: begin
                  bus_sel = src_sel;
                  state_d = ST_MEM;
               end
               default: ;
            endcase
         end

         ST_MEM: begin
            mem_req = 1'b1;
            if (opcode == OP_LOAD) begin
               bus_sel = addr_sel;
               if (mem_ack) ld_en[SEL_DR] = 1'b1;
            end else begin
               bus_sel = src_sel;
               mem_we  = 1'b1;
            end
            if (mem_ack) begin
               state_d = ST_FETCH;
            end else if (timeout) begin
               fault_d = FAULT_TIMEOUT;
               state_d = ST_HALT;
            end
         end

         // ir is not reloaded after FETCH, so the last select is recomputed.
         ST_HALT: begin
            halted = 1'b1;
            if (fault_q == FAULT_TIMEOUT && opcode == OP_LOAD)
               bus_sel = addr_sel;
            else if (fault_q == FAULT_TIMEOUT && opcode == OP_STORE)
               bus_sel = src_sel;
         end

         default: state_d = ST_FETCH;
      endcase

      if (!rst_n) begin
         bus_sel = SEL_PC;
         ld_en   = '0;
         alu_op  = ALU_PASS;
         ir_load = 1'b0;
         pc_inc  = 1'b0;
         mem_req = 1'b0;
         mem_we  = 1'b0;
         halted  = 1'b0;
         fault   = FAULT_NONE;
      end
   end

endmodule

// File: tb/tb_bus_ctrl_fsm.sv
// Scoreboard bench for bus_ctrl_fsm: directed cycles push expected output
// vectors; a negedge monitor pops and compares them.
module tb_bus_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ir;
   logic        zero_flag;
   logic        mem_ack;
   logic [3:0]  bus_sel;
   logic [15:0] ld_en;
   logic [2:0]  alu_op;
   logic        ir_load, pc_inc, mem_req, mem_we, halted;
   logic [1:0]  fault;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [29:0] v;
   } exp_t;

   exp_t sb[$];

   bus_ctrl_fsm #(.TIMEOUT_CYCLES(4), .ADDR_SRC_SEL(4'b1001)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .zero_flag(zero_flag),
      .mem_ack(mem_ack), .bus_sel(bus_sel), .ld_en(ld_en), .alu_op(alu_op),
      .ir_load(ir_load), .pc_inc(pc_inc), .mem_req(mem_req), .mem_we(mem_we),
      .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   // {bus_sel, ld_en, alu_op, ir_load, pc_inc, mem_req, mem_we, halted, fault}
   function automatic logic [29:0] pk(input logic [3:0] sel, input logic [15:0] ld,
                                      input logic [2:0] alu, input logic irl,
                                      input logic pci, input logic req, input logic we,
                                      input logic hlt, input logic [1:0] flt);
      return {sel, ld, alu, irl, pci, req, we, hlt, flt};
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t x;
         logic [29:0] act;
         x   = sb.pop_front();
         act = {bus_sel, ld_en, alu_op, ir_load, pc_inc, mem_req, mem_we, halted, fault};
         checks++;
         if (act !== x.v) begin
            errors++;
            $display("FAIL %s: got %h required %h (sel/ld/alu/irl/pci/req/we/hlt/flt)",
                     x.name, act, x.v);
         end
      end
   end

   task automatic step(input logic ack, input string nm, input logic [29:0] v);
      exp_t x;
      mem_ack = ack;
      x.name  = nm;
      x.v     = v;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   logic [29:0] V_RST, V_FETCH, V_FACK, V_DEC, V_IDLE;

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b1, "reset_ack_ignored", V_RST);
      rst_n = 1'b1;
   endtask

   initial begin
      V_RST   = pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd0);
      V_FETCH = pk(4'hA, 16'h0, 3'd0, 0, 0, 1, 0, 0, 2'd0);
      V_FACK  = pk(4'hA, 16'h0, 3'd0, 1, 1, 1, 0, 0, 2'd0);
      V_DEC   = pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd0);
      V_IDLE  = V_DEC;

      rst_n = 1'b0; ir = '0; zero_flag = 1'b0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step(0, "reset_state", V_RST);
      rst_n = 1'b1;
      step(0, "fetch_after_release", V_FETCH);
      // reset mid-FETCH: request drops at once, ack during reset discarded
      rst_n = 1'b0;
      step(0, "reset_mid_fetch", V_RST);
      step(1, "reset_ack_discarded", V_RST);
      rst_n = 1'b1;
      step(0, "fetch_restart", V_FETCH);

      ir = 16'h1360;
      step(1, "mov_fetch", V_FACK);
      step(0, "mov_decode", V_DEC);
      step(0, "mov_exec", pk(4'h3, 16'h0040, 3'd0, 0, 0, 0, 0, 0, 2'd0));

      ir = 16'h2100;
      step(1, "add_fetch_cycle4", V_FACK);
      step(0, "add_decode", V_DEC);
      step(0, "add_exec", pk(4'h1, 16'h0200, 3'd1, 0, 0, 0, 0, 0, 2'd0));

      ir = 16'h3500;
      step(1, "sub_fetch", V_FACK);
      step(0, "sub_decode", V_DEC);
      step(0, "sub_exec", pk(4'h5, 16'h0200, 3'd2, 0, 0, 0, 0, 0, 2'd0));

      ir = 16'h6600;
      step(1, "jmp_fetch", V_FACK);
      step(0, "jmp_decode", V_DEC);
      step(0, "jmp_exec", pk(4'h6, 16'h0400, 3'd0, 0, 0, 0, 0, 0, 2'd0));

      ir = 16'h7200; zero_flag = 1'b0;
      step(1, "jz_nt_fetch", V_FACK);
      step(0, "jz_nt_decode", V_DEC);
      step(0, "jz_not_taken", V_IDLE);

      ir = 16'h7200; zero_flag = 1'b1;
      step(1, "jz_t_fetch", V_FACK);
      step(0, "jz_t_decode", V_DEC);
      step(0, "jz_taken", pk(4'h2, 16'h0400, 3'd0, 0, 0, 0, 0, 0, 2'd0));
      zero_flag = 1'b0;

      ir = 16'h0000;
      step(1, "nop_fetch", V_FACK);
      step(0, "nop_decode", V_DEC);
      step(0, "nop_exec", V_IDLE);

      ir = 16'h4000;
      step(1, "load_fetch", V_FACK);
      step(0, "load_decode", V_DEC);
      step(0, "load_exec", pk(4'h9, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd0));
      step(0, "load_mem_wait1", pk(4'h9, 16'h0, 3'd0, 0, 0, 1, 0, 0, 2'd0));
      step(0, "load_mem_wait2", pk(4'h9, 16'h0, 3'd0, 0, 0, 1, 0, 0, 2'd0));
      step(1, "load_mem_ack", pk(4'h9, 16'h0040, 3'd0, 0, 0, 1, 0, 0, 2'd0));

      ir = 16'h5700;
      step(0, "store_fetch_wait", V_FETCH);
      step(1, "store_fetch", V_FACK);
      step(1, "store_decode_ack_ignored", V_DEC);
      step(1, "store_exec_ack_ignored", pk(4'h7, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd0));
      step(1, "store_mem_ack", pk(4'h7, 16'h0, 3'd0, 0, 0, 1, 1, 0, 2'd0));

      ir = 16'h1B00;
      step(1, "illsrc_fetch", V_FACK);
      step(0, "illsrc_decode", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd2));
      step(1, "illsrc_halt", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 1, 2'd2));
      step(0, "illsrc_halt_held", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 1, 2'd2));
      do_reset();

      ir = 16'h8000;
      step(1, "illop_fetch", V_FACK);
      step(0, "illop_decode", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd1));
      step(0, "illop_halt", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 1, 2'd1));
      do_reset();

      ir = 16'h1380;
      step(1, "illdst_fetch", V_FACK);
      step(0, "illdst_decode", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd2));
      step(0, "illdst_halt", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 1, 2'd2));
      do_reset();

      ir = 16'hF000;
      step(1, "halt_fetch", V_FACK);
      step(0, "halt_decode", V_DEC);
      step(1, "halt_state", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 1, 2'd0));
      do_reset();

`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 4; i++) step(0, "tmo_fetch_wait", V_FETCH);
      step(0, "tmo_fetch_halt", pk(4'hA, 16'h0, 3'd0, 0, 0, 0, 0, 1, 2'd3));
      do_reset();
      for (int i = 0; i < 3; i++) step(0, "tmo_ack_wins_wait", V_FETCH);
      ir = 16'h4000;
      step(1, "tmo_ack_wins", V_FACK);
      step(0, "tmo_load_decode", V_DEC);
      step(0, "tmo_load_exec", pk(4'h9, 16'h0, 3'd0, 0, 0, 0, 0, 0, 2'd0));
      for (int i = 0; i < 4; i++)
         step(0, "tmo_mem_wait", pk(4'h9, 16'h0, 3'd0, 0, 0, 1, 0, 0, 2'd0));
      step(0, "tmo_mem_halt", pk(4'h9, 16'h0, 3'd0, 0, 0, 0, 0, 1, 2'd3));
`else
      for (int i = 0; i < 8; i++) step(0, "no_timeout_wait", V_FETCH);
      ir = 16'h0000;
      step(1, "no_timeout_late_ack", V_FACK);
      step(0, "no_timeout_decode", V_DEC);
`endif

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
